// File: rtl/vdp_bus_pkg.sv
// Shared types and constants for the VDP host-bus bridge.
package vdp_bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2,
      HOLD   = 2'd3
   } bridge_state_e;

   localparam logic [1:0] PORT_VRAM = 2'd0;
   localparam logic [1:0] PORT_CTRL = 2'd1;
   localparam logic [1:0] PORT_PAL  = 2'd2;
   localparam logic [1:0] PORT_IND  = 2'd3;

endpackage

// File: rtl/strobe_filter.sv
// Synchroniser plus N-sample level filter for one active-low host strobe.
module strobe_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic strobe_n,
   output logic filt_n
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] CNT_RELOAD = CW'(FILTER_LEN - 1);

   // The filter register itself is the final synchroniser stage, so only
   // SYNC_STAGES-1 plain flops precede it.
   logic [SYNC_STAGES-2:0] sync_q, sync_d;
   logic                   filt_q, filt_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   sample;

   always_comb begin
      sync_d[0] = strobe_n;
      for (int i = 1; i < SYNC_STAGES - 1; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      sample = sync_q[SYNC_STAGES-2];
      filt_d = filt_q;
      cnt_d  = CNT_RELOAD;
      if (sample != filt_q) begin
         if (cnt_q == '0) begin
            filt_d = sample;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '1;
         filt_q <= 1'b1;
         cnt_q  <= CNT_RELOAD;
      end else begin
         sync_q <= sync_d;
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign filt_n = filt_q;

endmodule

// File: rtl/vdp_cpu_bridge.sv
// Host-bus front end: deglitched strobes in, one req/wrt transaction per host access out.
//  state  | meaning
//  IDLE   | waiting for exactly one filtered strobe
//  ISSUE  | req pulse on the bus this cycle
//  RDWAIT | read latency timer running, vdp_dbi captured at terminal count
//  HOLD   | access done, waiting for both strobes to release
module vdp_cpu_bridge
   import vdp_bus_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int READ_LAT    = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       csr_n,
   input  logic       csw_n,
   input  logic [1:0] mode,
   input  logic [7:0] cd_i,
   input  logic [7:0] vdp_dbi,
   output logic       req,
   output logic       wrt,
   output logic [1:0] adr,
   output logic [7:0] dbo,
   output logic [7:0] cd_o,
   output logic       cd_oe,
   output logic       conflict
);

   localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam logic [LW-1:0] LAT_RELOAD = LW'(READ_LAT - 1);

   logic          rd_filt_n, wr_filt_n, rd_act, wr_act;
   logic [1:0]    mode_sync_q [SYNC_STAGES];
   logic [1:0]    mode_sync_d [SYNC_STAGES];
   logic [7:0]    cd_sync_q   [SYNC_STAGES];
   logic [7:0]    cd_sync_d   [SYNC_STAGES];

   bridge_state_e state_q, state_d;
   logic          req_q, req_d, wrt_q, wrt_d, cd_oe_q, cd_oe_d;
   logic          conflict_q, conflict_d, rd_q, rd_d, cap_q, cap_d;
   logic [1:0]    adr_q, adr_d;
   logic [7:0]    dbo_q, dbo_d, cd_o_q, cd_o_d;
   logic [LW-1:0] lat_q, lat_d;

   strobe_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_rd_filt (
      .clk(clk), .reset_n(reset_n), .strobe_n(csr_n), .filt_n(rd_filt_n));
   strobe_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_wr_filt (
      .clk(clk), .reset_n(reset_n), .strobe_n(csw_n), .filt_n(wr_filt_n));

   assign rd_act = ~rd_filt_n;
   assign wr_act = ~wr_filt_n;

   // Same depth as the strobe path so mode/cd line up with the filtered edge.
   always_comb begin
      mode_sync_d[0] = mode;
      cd_sync_d[0]   = cd_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         mode_sync_d[i] = mode_sync_q[i-1];
         cd_sync_d[i]   = cd_sync_q[i-1];
      end
   end

   always_comb begin
      state_d    = state_q;
      req_d      = 1'b0;
      wrt_d      = 1'b0;
      conflict_d = 1'b0;
      adr_d      = adr_q;
      dbo_d      = dbo_q;
      cd_o_d     = cd_o_q;
      rd_d       = rd_q;
      cap_d      = cap_q;
      lat_d      = lat_q;
      case (state_q)
         IDLE: begin
            if (rd_act && wr_act) begin
               conflict_d = 1'b1;
               rd_d       = 1'b0;
               state_d    = HOLD;
            end else if (rd_act || wr_act) begin
               req_d   = 1'b1;
               wrt_d   = wr_act;
               adr_d   = mode_sync_q[SYNC_STAGES-1];
               if (wr_act) dbo_d = cd_sync_q[SYNC_STAGES-1];
               rd_d    = rd_act;
               cap_d   = 1'b0;
               lat_d   = LAT_RELOAD;
               state_d = ISSUE;
            end
         end
         ISSUE, RDWAIT: begin
            if (!rd_q || cap_q) begin
               state_d = HOLD;
            end else begin
               state_d = RDWAIT;
               if (lat_q == '0) begin
                  cd_o_d = vdp_dbi;
                  cap_d  = 1'b1;
               end else begin
                  lat_d = lat_q - 1'b1;
               end
            end
         end
         HOLD: begin
            if (!rd_act && !wr_act) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Bus drive starts the cycle after capture and ends on leaving HOLD.
      cd_oe_d = rd_d && cap_q && ((state_d == RDWAIT) || (state_d == HOLD));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            mode_sync_q[i] <= '0;
            cd_sync_q[i]   <= '0;
         end
         state_q    <= IDLE;
         req_q      <= 1'b0;
         wrt_q      <= 1'b0;
         conflict_q <= 1'b0;
         adr_q      <= '0;
         dbo_q      <= '0;
         cd_o_q     <= '0;
         cd_oe_q    <= 1'b0;
         rd_q       <= 1'b0;
         cap_q      <= 1'b0;
         lat_q      <= '0;
      end else begin
         mode_sync_q <= mode_sync_d;
         cd_sync_q   <= cd_sync_d;
         state_q     <= state_d;
         req_q       <= req_d;
         wrt_q       <= wrt_d;
         conflict_q  <= conflict_d;
         adr_q       <= adr_d;
         dbo_q       <= dbo_d;
         cd_o_q      <= cd_o_d;
         cd_oe_q     <= cd_oe_d;
         rd_q        <= rd_d;
         cap_q       <= cap_d;
         lat_q       <= lat_d;
      end
   end

   assign req      = req_q;
   assign wrt      = wrt_q;
   assign adr      = adr_q;
   assign dbo      = dbo_q;
   assign cd_o     = cd_o_q;
   assign cd_oe    = cd_oe_q;
   assign conflict = conflict_q;

endmodule

// File: tb/tb_vdp_cpu_bridge.sv
// Scoreboard bench for vdp_cpu_bridge: directed host accesses, monitor checks req and read-drive events.
module tb_vdp_cpu_bridge;
   import vdp_bus_pkg::*;

   logic       clk = 1'b0;
   logic       reset_n, csr_n, csw_n;
   logic [1:0] mode;
   logic [7:0] cd_i, vdp_dbi;
   logic       req, wrt, cd_oe, conflict;
   logic [1:0] adr;
   logic [7:0] dbo, cd_o;

   typedef struct {
      int         cyc;
      logic       wrt;
      logic [1:0] adr;
      logic [7:0] dbo;
   } req_exp_t;

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } rd_exp_t;

   req_exp_t req_exp[$];
   rd_exp_t  rd_exp[$];
   req_exp_t mon_req;
   rd_exp_t  mon_rd;

   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;
   int   conf_cnt = 0;
   logic oe_prev = 1'b0;

   vdp_cpu_bridge #(.SYNC_STAGES(2), .FILTER_LEN(3), .READ_LAT(1)) dut (
      .clk(clk), .reset_n(reset_n), .csr_n(csr_n), .csw_n(csw_n),
      .mode(mode), .cd_i(cd_i), .vdp_dbi(vdp_dbi),
      .req(req), .wrt(wrt), .adr(adr), .dbo(dbo),
      .cd_o(cd_o), .cd_oe(cd_oe), .conflict(conflict));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents req or starts driving cd.
   always @(negedge clk) begin
      if (reset_n) begin
         if (req) begin
            if (req_exp.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_req at cycle %0d: wrt=%0b adr=%0d dbo=0x%0h", cyc, wrt, adr, dbo);
            end else begin
               mon_req = req_exp.pop_front();
               check("req_cycle", cyc, mon_req.cyc);
               check("req_wrt", int'(wrt), int'(mon_req.wrt));
               check("req_adr", int'(adr), int'(mon_req.adr));
               if (mon_req.wrt) check("req_dbo", int'(dbo), int'(mon_req.dbo));
            end
         end
         if (cd_oe && !oe_prev) begin
            if (rd_exp.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_cd_oe at cycle %0d: cd_o=0x%0h", cyc, cd_o);
            end else begin
               mon_rd = rd_exp.pop_front();
               check("cd_oe_rise_cycle", cyc, mon_rd.cyc);
               check("cd_o_data", int'(cd_o), int'(mon_rd.data));
            end
         end
         if (conflict) conf_cnt++;
      end
      oe_prev = cd_oe;
   end

   task automatic push_req(input int c, input logic w, input logic [1:0] a, input logic [7:0] d);
      req_exp_t e;
      e.cyc = c; e.wrt = w; e.adr = a; e.dbo = d;
      req_exp.push_back(e);
   endtask

   task automatic push_rd(input int c, input logic [7:0] d);
      rd_exp_t e;
      e.cyc = c; e.data = d;
      rd_exp.push_back(e);
   endtask

   // One host access: strobe low for 'low' cycles starting at the next falling edge.
   task automatic access(input bit is_rd, input logic [1:0] m, input logic [7:0] d, input int low);
      int t0;
      @(negedge clk);
      t0   = cyc;
      mode = m;
      cd_i = d;
      if (is_rd) vdp_dbi = d;
      if (low >= 3) begin
         push_req(t0 + 5, !is_rd, m, d);
         if (is_rd) push_rd(t0 + 7, d);
      end
      if (is_rd) csr_n = 1'b0; else csw_n = 1'b0;
      repeat (low) @(negedge clk);
      csr_n = 1'b1;
      csw_n = 1'b1;
      if (is_rd && low >= 8) begin
         repeat (4) @(negedge clk);
         check("cd_oe_before_release_done", int'(cd_oe), 1);
         @(negedge clk);
         check("cd_oe_after_release", int'(cd_oe), 0);
      end
   endtask

   initial begin
      int c0, q;
      reset_n = 1'b0;
      csr_n   = 1'b1;
      csw_n   = 1'b1;
      mode    = 2'd0;
      cd_i    = 8'h00;
      vdp_dbi = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_req", int'(req), 0);
      check("rst_wrt", int'(wrt), 0);
      check("rst_adr", int'(adr), 0);
      check("rst_dbo", int'(dbo), 0);
      check("rst_cd_o", int'(cd_o), 0);
      check("rst_cd_oe", int'(cd_oe), 0);
      check("rst_conflict", int'(conflict), 0);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      access(1'b0, PORT_CTRL, 8'h8F, 20);
      repeat (15) @(negedge clk);

      access(1'b1, PORT_VRAM, 8'h5A, 20);
      repeat (10) @(negedge clk);

      access(1'b0, PORT_PAL, 8'hE7, 2);
      repeat (15) @(negedge clk);
      access(1'b0, PORT_IND, 8'h3D, 3);
      repeat (15) @(negedge clk);

      c0 = conf_cnt;
      @(negedge clk);
      csr_n = 1'b0;
      csw_n = 1'b0;
      repeat (10) @(negedge clk);
      csr_n = 1'b1;
      csw_n = 1'b1;
      repeat (12) @(negedge clk);
      check("conflict_pulses", conf_cnt - c0, 1);
      access(1'b0, PORT_PAL, 8'hA5, 12);
      repeat (15) @(negedge clk);

      access(1'b0, PORT_VRAM, 8'h11, 12);
      repeat (11) @(negedge clk);
      access(1'b0, PORT_VRAM, 8'h22, 12);
      repeat (15) @(negedge clk);

      @(negedge clk);
      c0      = cyc;
      mode    = PORT_VRAM;
      vdp_dbi = 8'h3C;
      push_req(c0 + 5, 1'b0, PORT_VRAM, 8'h00);
      push_rd(c0 + 7, 8'h3C);
      csr_n = 1'b0;
      repeat (12) @(negedge clk);
      check("mid_read_cd_oe", int'(cd_oe), 1);
      reset_n = 1'b0;
      #1;
      check("reset_cd_oe", int'(cd_oe), 0);
      check("reset_req", int'(req), 0);
      check("reset_cd_o", int'(cd_o), 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      q       = cyc;
      vdp_dbi = 8'hC3;
      push_req(q + 5, 1'b0, PORT_VRAM, 8'h00);
      push_rd(q + 7, 8'hC3);
      repeat (15) @(negedge clk);
      csr_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_reset_cd_oe_hold", int'(cd_oe), 1);
      @(negedge clk);
      check("post_reset_cd_oe_release", int'(cd_oe), 0);

      repeat (20) @(negedge clk);
      check("req_scoreboard_drained", req_exp.size(), 0);
      check("rd_scoreboard_drained", rd_exp.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
